// File: rtl/types_pkg.sv
// Shared types for the branch checkpoint controller: slot ids, FSM states, slot record.
package types_pkg;

    localparam int unsigned NUM_CKPT_DEF = 4;
    localparam int unsigned TAG_W_DEF    = 5;

    typedef logic [$clog2(NUM_CKPT_DEF)-1:0] ckpt_id_t;

    typedef enum logic [0:0] {
        CK_IDLE,
        CK_RECOVER
    } ckpt_ctrl_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        ckpt_id_t             age;
    } ckpt_slot_t;

endpackage

// File: rtl/ckpt_age_tracker.sv
// Valid/age bookkeeping for checkpoint slots: alloc, free with age compaction, and
// squash of a slot plus every younger slot. Also provides valid count and lowest free slot.
module ckpt_age_tracker
    import types_pkg::*;
#(
    parameter int unsigned NUM_CKPT = NUM_CKPT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_en,
    input  logic [$clog2(NUM_CKPT)-1:0]   alloc_slot,
    input  logic                          free_en,
    input  logic [$clog2(NUM_CKPT)-1:0]   free_slot,
    input  logic                          squash,
    output logic [NUM_CKPT-1:0]           valid,
    output logic [NUM_CKPT-1:0]           clear_mask,
    output logic [$clog2(NUM_CKPT+1)-1:0] count,
    output logic [$clog2(NUM_CKPT)-1:0]   free_idx
);

    localparam int unsigned IDW = $clog2(NUM_CKPT);
    localparam int unsigned CW  = $clog2(NUM_CKPT + 1);

    logic [NUM_CKPT-1:0]          valid_q, valid_d;
    logic [NUM_CKPT-1:0][IDW-1:0] age_q, age_d;
    logic [IDW-1:0]               free_age;

    assign valid    = valid_q;
    assign free_age = age_q[free_slot];

    always_comb begin
        clear_mask = '0;
        if (free_en) begin
            clear_mask[free_slot] = 1'b1;
            if (squash) begin
                for (int i = 0; i < NUM_CKPT; i++) begin
                    if (valid_q[i] && (age_q[i] > free_age)) clear_mask[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_CKPT; i++) count = count + CW'(valid_q[i]);
    end

    // Scan downward so the lowest free index wins.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDW'(i);
        end
    end

    always_comb begin
        valid_d = valid_q & ~clear_mask;
        age_d   = age_q;
        if (free_en && !squash) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (valid_q[i] && (age_q[i] > free_age)) age_d[i] = age_q[i] - IDW'(1);
            end
        end
        // New slot is youngest after any same-cycle compaction.
        if (alloc_en) begin
            valid_d[alloc_slot] = 1'b1;
            age_d[alloc_slot]   = IDW'(count - CW'(free_en && !squash));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: rtl/ckpt_ctrl.sv
// Branch checkpoint allocation/recovery controller. Perf counters are built only when
// CKPT_CTRL_PERF_EN is defined; otherwise the perf ports are tied to zero.
module ckpt_ctrl
    import types_pkg::*;
#(
    parameter int unsigned NUM_CKPT       = NUM_CKPT_DEF,
    parameter int unsigned TAG_W          = TAG_W_DEF,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_req,
    input  logic [TAG_W-1:0]            alloc_tag,
    output logic                        alloc_grant,
    output logic [$clog2(NUM_CKPT)-1:0] alloc_slot,
    output logic                        full,
    output logic                        rename_stall,
    input  logic                        resolve_valid,
    output logic                        resolve_ready,
    input  logic [TAG_W-1:0]            resolve_tag,
    input  logic                        resolve_mispredict,
    output logic                        restore_valid,
    output logic [$clog2(NUM_CKPT)-1:0] restore_slot,
    output logic [NUM_CKPT-1:0]         flush_mask,
    output logic [31:0]                 perf_alloc,
    output logic [31:0]                 perf_stall,
    output logic [31:0]                 perf_mispred
);

    localparam int unsigned IDW   = $clog2(NUM_CKPT);
    localparam int unsigned CW    = $clog2(NUM_CKPT + 1);
    localparam int unsigned CNT_W = $clog2(RECOVER_CYCLES) + 1;

    ckpt_ctrl_state_e             state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NUM_CKPT-1:0][TAG_W-1:0] tag_q;
    logic [NUM_CKPT-1:0]          valid;
    logic [CW-1:0]                count;
    logic [IDW-1:0]               free_idx, match_idx;
    logic                         idle, hs, match, hit, mispred;

    assign idle = (state_q == CK_IDLE);
    assign hs   = resolve_valid & idle;

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (valid[i] && (tag_q[i] == resolve_tag)) begin
                match     = 1'b1;
                match_idx = IDW'(i);
            end
        end
    end

    assign hit     = hs & match;
    assign mispred = hit & resolve_mispredict;

    assign full          = (count == CW'(NUM_CKPT));
    assign rename_stall  = full | ~idle;
    assign resolve_ready = idle;
    // Any mispredict handshake blocks allocation, matched or not.
    assign alloc_grant   = alloc_req & ~full & idle & ~(hs & resolve_mispredict);
    assign alloc_slot    = alloc_grant ? free_idx : '0;
    assign restore_valid = mispred;
    assign restore_slot  = mispred ? match_idx : '0;

    ckpt_age_tracker #(
        .NUM_CKPT (NUM_CKPT)
    ) u_age (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (alloc_grant),
        .alloc_slot (alloc_slot),
        .free_en    (hit),
        .free_slot  (match_idx),
        .squash     (resolve_mispredict),
        .valid      (valid),
        .clear_mask (flush_mask),
        .count      (count),
        .free_idx   (free_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else if (alloc_grant) begin
            tag_q[alloc_slot] <= alloc_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CK_IDLE: begin
                if (mispred) begin
                    state_d = CK_RECOVER;
                    cnt_d   = CNT_W'(RECOVER_CYCLES - 1);
                end
            end
            CK_RECOVER: begin
                if (cnt_q == '0) state_d = CK_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = CK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CK_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CKPT_CTRL_PERF_EN
    logic [31:0] perf_alloc_q, perf_stall_q, perf_mispred_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_alloc_q   <= '0;
            perf_stall_q   <= '0;
            perf_mispred_q <= '0;
        end else begin
            if (alloc_grant && (perf_alloc_q != '1)) perf_alloc_q <= perf_alloc_q + 32'd1;
            if (alloc_req && rename_stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (mispred && (perf_mispred_q != '1)) perf_mispred_q <= perf_mispred_q + 32'd1;
        end
    end

    assign perf_alloc   = perf_alloc_q;
    assign perf_stall   = perf_stall_q;
    assign perf_mispred = perf_mispred_q;
`else
    assign perf_alloc   = '0;
    assign perf_stall   = '0;
    assign perf_mispred = '0;
`endif

endmodule

// File: tb/tb_ckpt_ctrl.sv
// Directed self-checking bench for ckpt_ctrl (4 slots, 5-bit tags, 2 recovery cycles).
module tb_ckpt_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic [4:0] alloc_tag;
    logic       alloc_grant;
    logic [1:0] alloc_slot;
    logic       full;
    logic       rename_stall;
    logic       resolve_valid;
    logic       resolve_ready;
    logic [4:0] resolve_tag;
    logic       resolve_mispredict;
    logic       restore_valid;
    logic [1:0] restore_slot;
    logic [3:0] flush_mask;
    logic [31:0] perf_alloc, perf_stall, perf_mispred;

    int n_vec = 0;
    int n_err = 0;

    ckpt_ctrl #(
        .NUM_CKPT       (4),
        .TAG_W          (5),
        .RECOVER_CYCLES (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .alloc_req          (alloc_req),
        .alloc_tag          (alloc_tag),
        .alloc_grant        (alloc_grant),
        .alloc_slot         (alloc_slot),
        .full               (full),
        .rename_stall       (rename_stall),
        .resolve_valid      (resolve_valid),
        .resolve_ready      (resolve_ready),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .restore_valid      (restore_valid),
        .restore_slot       (restore_slot),
        .flush_mask         (flush_mask),
        .perf_alloc         (perf_alloc),
        .perf_stall         (perf_stall),
        .perf_mispred       (perf_mispred)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; alloc_req = 1'b0; alloc_tag = '0;
        resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic fill(input int n);
        logic [4:0] tags [4];
        tags = '{5'd3, 5'd7, 5'd9, 5'd12};
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1; alloc_tag = tags[i];
            cyc();
        end
        alloc_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL rst_grant: got %b want 0", alloc_grant); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
        n_vec++; if (rename_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", rename_stall); end
        n_vec++; if (resolve_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", resolve_ready); end
        n_vec++; if (flush_mask !== 4'b0000) begin n_err++; $display("FAIL rst_flush: got %b want 0000", flush_mask); end
        n_vec++; if (restore_valid !== 1'b0) begin n_err++; $display("FAIL rst_restore: got %b want 0", restore_valid); end
`ifndef CKPT_CTRL_PERF_EN
        n_vec++; if ((perf_alloc | perf_stall | perf_mispred) !== 32'd0) begin
            n_err++; $display("FAIL rst_perf: got %h/%h/%h want 0", perf_alloc, perf_stall, perf_mispred);
        end
`endif
    endtask

    task automatic test_fill();
        logic [4:0] tags [4];
        tags = '{5'd3, 5'd7, 5'd9, 5'd12};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1; alloc_tag = tags[i];
            #1;
            n_vec++; if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL fill_grant%0d: got %b want 1", i, alloc_grant); end
            n_vec++; if (alloc_slot !== 2'(i)) begin n_err++; $display("FAIL fill_slot%0d: got %0d want %0d", i, alloc_slot, i); end
            cyc();
        end
        alloc_tag = 5'd20;
        #1;
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        n_vec++; if (rename_stall !== 1'b1) begin n_err++; $display("FAIL fill_stall: got %b want 1", rename_stall); end
        n_vec++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL fill_5th_grant: got %b want 0", alloc_grant); end
        alloc_req = 1'b0;
    endtask

    task automatic test_hit();
        do_reset();
        fill(4);
        resolve_valid = 1'b1; resolve_tag = 5'd7; resolve_mispredict = 1'b0;
        #1;
        n_vec++; if (flush_mask !== 4'b0010) begin n_err++; $display("FAIL hit_flush: got %b want 0010", flush_mask); end
        n_vec++; if (restore_valid !== 1'b0) begin n_err++; $display("FAIL hit_restore: got %b want 0", restore_valid); end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL hit_full_same_cycle: got %b want 1", full); end
        cyc();
        resolve_valid = 1'b0;
        alloc_req = 1'b1; alloc_tag = 5'd14;
        #1;
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL hit_full_next: got %b want 0", full); end
        n_vec++; if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL hit_realloc_grant: got %b want 1", alloc_grant); end
        n_vec++; if (alloc_slot !== 2'd1) begin n_err++; $display("FAIL hit_realloc_slot: got %0d want 1", alloc_slot); end
        cyc();
        alloc_req = 1'b0;
        // Ages now: s0=0 (t3), s2=1 (t9), s3=2 (t12), s1=3 (t14).
        resolve_valid = 1'b1; resolve_tag = 5'd9; resolve_mispredict = 1'b1;
        #1;
        n_vec++; if (flush_mask !== 4'b1110) begin n_err++; $display("FAIL hit_age_squash: got %b want 1110", flush_mask); end
        n_vec++; if (restore_slot !== 2'd2) begin n_err++; $display("FAIL hit_age_restore_slot: got %0d want 2", restore_slot); end
        cyc();
        resolve_valid = 1'b0;
    endtask

    task automatic test_mispredict();
        do_reset();
        fill(4);
        resolve_valid = 1'b1; resolve_tag = 5'd7; resolve_mispredict = 1'b1;
        #1;
        n_vec++; if (restore_valid !== 1'b1) begin n_err++; $display("FAIL mp_restore: got %b want 1", restore_valid); end
        n_vec++; if (restore_slot !== 2'd1) begin n_err++; $display("FAIL mp_restore_slot: got %0d want 1", restore_slot); end
        n_vec++; if (flush_mask !== 4'b1110) begin n_err++; $display("FAIL mp_flush: got %b want 1110", flush_mask); end
        cyc();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        alloc_req = 1'b1; alloc_tag = 5'd4;
        #1;
        n_vec++; if (rename_stall !== 1'b1) begin n_err++; $display("FAIL mp_stall_t1: got %b want 1", rename_stall); end
        n_vec++; if (resolve_ready !== 1'b0) begin n_err++; $display("FAIL mp_ready_t1: got %b want 0", resolve_ready); end
        n_vec++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL mp_grant_t1: got %b want 0", alloc_grant); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL mp_full_t1: got %b want 0", full); end
        cyc();
        n_vec++; if (rename_stall !== 1'b1) begin n_err++; $display("FAIL mp_stall_t2: got %b want 1", rename_stall); end
        n_vec++; if (resolve_ready !== 1'b0) begin n_err++; $display("FAIL mp_ready_t2: got %b want 0", resolve_ready); end
        cyc();
        n_vec++; if (rename_stall !== 1'b0) begin n_err++; $display("FAIL mp_stall_t3: got %b want 0", rename_stall); end
        n_vec++; if (resolve_ready !== 1'b1) begin n_err++; $display("FAIL mp_ready_t3: got %b want 1", resolve_ready); end
        n_vec++; if (alloc_slot !== 2'd1) begin n_err++; $display("FAIL mp_alloc_t3: got %0d want 1", alloc_slot); end
        cyc();
        alloc_req = 1'b0;
    endtask

    task automatic test_alloc_mispred();
        do_reset();
        fill(2);
        alloc_req = 1'b1; alloc_tag = 5'd9;
        resolve_valid = 1'b1; resolve_tag = 5'd7; resolve_mispredict = 1'b1;
        #1;
        n_vec++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL am_grant: got %b want 0", alloc_grant); end
        n_vec++; if (flush_mask !== 4'b0010) begin n_err++; $display("FAIL am_flush: got %b want 0010", flush_mask); end
        n_vec++; if (restore_slot !== 2'd1) begin n_err++; $display("FAIL am_restore_slot: got %0d want 1", restore_slot); end
        cyc();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0; alloc_req = 1'b0;
        cyc();
        cyc();
        alloc_req = 1'b1; alloc_tag = 5'd10;
        #1;
        n_vec++; if (alloc_slot !== 2'd1) begin n_err++; $display("FAIL am_alloc_a: got %0d want 1", alloc_slot); end
        cyc();
        n_vec++; if (alloc_slot !== 2'd2) begin n_err++; $display("FAIL am_alloc_b: got %0d want 2", alloc_slot); end
        cyc();
        alloc_req = 1'b0;
    endtask

    task automatic test_unknown_tag();
        do_reset();
        fill(4);
        resolve_valid = 1'b1; resolve_tag = 5'd20; resolve_mispredict = 1'b0;
        #1;
        n_vec++; if (flush_mask !== 4'b0000) begin n_err++; $display("FAIL unk_hit_flush: got %b want 0000", flush_mask); end
        cyc();
        resolve_mispredict = 1'b1;
        #1;
        n_vec++; if (flush_mask !== 4'b0000) begin n_err++; $display("FAIL unk_mp_flush: got %b want 0000", flush_mask); end
        n_vec++; if (restore_valid !== 1'b0) begin n_err++; $display("FAIL unk_mp_restore: got %b want 0", restore_valid); end
        cyc();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        #1;
        n_vec++; if (resolve_ready !== 1'b1) begin n_err++; $display("FAIL unk_ready: got %b want 1", resolve_ready); end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL unk_full: got %b want 1", full); end
    endtask

    task automatic test_reset_recover();
        do_reset();
        fill(4);
        resolve_valid = 1'b1; resolve_tag = 5'd3; resolve_mispredict = 1'b1;
        #1;
        n_vec++; if (flush_mask !== 4'b1111) begin n_err++; $display("FAIL rr_flush: got %b want 1111", flush_mask); end
        cyc();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0; reset = 1'b1;
        #1;
        n_vec++; if (rename_stall !== 1'b1) begin n_err++; $display("FAIL rr_stall_t1: got %b want 1", rename_stall); end
        cyc();
        reset = 1'b0;
        #1;
        n_vec++; if (rename_stall !== 1'b0) begin n_err++; $display("FAIL rr_stall_t2: got %b want 0", rename_stall); end
        n_vec++; if (resolve_ready !== 1'b1) begin n_err++; $display("FAIL rr_ready_t2: got %b want 1", resolve_ready); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rr_full_t2: got %b want 0", full); end
        cyc();
        alloc_req = 1'b1; alloc_tag = 5'd5;
        #1;
        n_vec++; if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL rr_grant_t3: got %b want 1", alloc_grant); end
        n_vec++; if (alloc_slot !== 2'd0) begin n_err++; $display("FAIL rr_slot_t3: got %0d want 0", alloc_slot); end
        cyc();
        alloc_tag = 5'd6;
        cyc();
        alloc_req = 1'b0;
        // Slot 0 must be oldest, so its mispredict also squashes slot 1.
        resolve_valid = 1'b1; resolve_tag = 5'd5; resolve_mispredict = 1'b1;
        #1;
        n_vec++; if (flush_mask !== 4'b0011) begin n_err++; $display("FAIL rr_age0: got %b want 0011", flush_mask); end
        cyc();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_mispredict();
        test_alloc_mispred();
        test_unknown_tag();
        test_reset_recover();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
